// File: rtl/bru_issue_queue_pkg.sv
// Shared widths and the packed BRU operation bundle used by the branch issue
// queue and by execute_bru.
package bru_issue_queue_pkg;

    localparam int PC_W       = 32;
    localparam int ROB_W      = 4;
    localparam int FID_W      = 8;
    localparam int IMM_W      = 26;
    localparam int BRU_CMD_W  = 7;
    localparam int BAGU_CMD_W = 2;
    localparam int BP_PAT_W   = 2;
    localparam int DATA_W     = 32;

    // Everything the branch unit needs to execute one op.
    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [DATA_W-1:0]     src0_value;
        logic [DATA_W-1:0]     src1_value;
        logic [ROB_W-1:0]      dst_rob;
        logic [IMM_W-1:0]      imm;
        logic [FID_W-1:0]      fid;
        logic [BRU_CMD_W-1:0]  bru_cmd;
        logic [BAGU_CMD_W-1:0] bagu_cmd;
        logic [BP_PAT_W-1:0]   bp_pattern;
        logic                  bp_taken;
        logic                  bp_hit;
        logic [PC_W-1:0]       bp_target;
    } bru_op_t;

    localparam int BRU_OP_W = $bits(bru_op_t);

endpackage

// File: rtl/bru_issue_age_select.sv
// Oldest-first selector: grants the candidate that no other candidate is older
// than. age[j][i]=1 means entry j is older than entry i.
module bru_issue_age_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);

    logic [DEPTH-1:0] older_s;

    // For each candidate, look for an older candidate; with no older one it wins.
    always_comb begin
        older_s = '0;
        grant   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_s[i] = older_s[i] | (cand[j] & age[j][i]);
            end
            grant[i] = cand[i] & ~older_s[i];
        end
        any = |cand;
    end

endmodule

// File: rtl/bru_issue_queue.sv
// Reservation station for the single branch unit. Holds dispatched branch ops,
// captures operands from the writeback bus by ROB tag and issues the oldest
// fully-ready entry each cycle. A mispredict flush empties the whole queue.
module bru_issue_queue
    import bru_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_dsp_valid,
    output logic                  o_dsp_ready,
    input  logic [PC_W-1:0]       i_dsp_pc,
    input  logic [ROB_W-1:0]      i_dsp_src0_rob,
    input  logic [ROB_W-1:0]      i_dsp_src1_rob,
    input  logic                  i_dsp_src0_rdy,
    input  logic                  i_dsp_src1_rdy,
    input  logic [DATA_W-1:0]     i_dsp_src0_value,
    input  logic [DATA_W-1:0]     i_dsp_src1_value,
    input  logic [ROB_W-1:0]      i_dsp_dst_rob,
    input  logic [IMM_W-1:0]      i_dsp_imm,
    input  logic [FID_W-1:0]      i_dsp_fid,
    input  logic [BRU_CMD_W-1:0]  i_dsp_bru_cmd,
    input  logic [BAGU_CMD_W-1:0] i_dsp_bagu_cmd,
    input  logic [BP_PAT_W-1:0]   i_dsp_bp_pattern,
    input  logic                  i_dsp_bp_taken,
    input  logic                  i_dsp_bp_hit,
    input  logic [PC_W-1:0]       i_dsp_bp_target,
    input  logic                  i_wb_valid,
    input  logic [ROB_W-1:0]      i_wb_rob,
    input  logic [DATA_W-1:0]     i_wb_value,
    input  logic                  i_flush,
    input  logic                  i_iss_ready,
    output logic                  o_iss_valid,
    output logic [PC_W-1:0]       o_iss_pc,
    output logic [DATA_W-1:0]     o_iss_src0_value,
    output logic [DATA_W-1:0]     o_iss_src1_value,
    output logic [ROB_W-1:0]      o_iss_dst_rob,
    output logic [IMM_W-1:0]      o_iss_imm,
    output logic [FID_W-1:0]      o_iss_fid,
    output logic [BRU_CMD_W-1:0]  o_iss_bru_cmd,
    output logic [BAGU_CMD_W-1:0] o_iss_bagu_cmd,
    output logic [BP_PAT_W-1:0]   o_iss_bp_pattern,
    output logic                  o_iss_bp_taken,
    output logic                  o_iss_bp_hit,
    output logic [PC_W-1:0]       o_iss_bp_target,
    output logic [CNT_W-1:0]      o_count
);

    // Registered entry state
    logic [DEPTH-1:0]              valid_r;
    logic [DEPTH-1:0]              src0_rdy_r;
    logic [DEPTH-1:0]              src1_rdy_r;
    logic [DEPTH-1:0][ROB_W-1:0]   src0_rob_r;
    logic [DEPTH-1:0][ROB_W-1:0]   src1_rob_r;
    bru_op_t [DEPTH-1:0]           op_r;
    logic [DEPTH-1:0][DEPTH-1:0]   age_r;
    logic [CNT_W-1:0]              count_r;

    // Combinational control
    logic [DEPTH-1:0]              alloc_s;
    logic                          taken_s;
    logic                          dsp_ready_s;
    logic                          dsp_acc_s;
    logic                          dsp_wake0_s;
    logic                          dsp_wake1_s;
    bru_op_t                       dsp_op_s;
    logic [DEPTH-1:0]              wake0_s;
    logic [DEPTH-1:0]              wake1_s;
    logic [DEPTH-1:0]              cand_s;
    logic [DEPTH-1:0]              grant_s;
    logic                          any_s;
    logic                          iss_valid_s;
    logic                          iss_fire_s;
    logic [DEPTH-1:0]              valid_nxt_s;
    logic [DEPTH-1:0][DEPTH-1:0]   age_nxt_s;
    logic [CNT_W-1:0]              count_nxt_s;
    bru_op_t                       sel_op_s;
    bru_op_t                       iss_op_s;

    // A slot only frees at the edge, so readiness looks at the registered count.
    assign dsp_ready_s = ~reset & (count_r != CNT_W'(DEPTH));
    assign dsp_acc_s   = i_dsp_valid & dsp_ready_s & ~i_flush;
    assign dsp_wake0_s = i_wb_valid & ~i_dsp_src0_rdy & (i_dsp_src0_rob == i_wb_rob);
    assign dsp_wake1_s = i_wb_valid & ~i_dsp_src1_rdy & (i_dsp_src1_rob == i_wb_rob);

    // Lowest-index free slot as a one-hot allocation vector.
    always_comb begin
        alloc_s = '0;
        taken_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_s[i] = ~valid_r[i] & ~taken_s;
            taken_s    = taken_s | ~valid_r[i];
        end
    end

    // Assemble the incoming op, folding in a writeback that lands on dispatch.
    always_comb begin
        dsp_op_s            = '0;
        dsp_op_s.pc         = i_dsp_pc;
        dsp_op_s.src0_value = dsp_wake0_s ? i_wb_value : i_dsp_src0_value;
        dsp_op_s.src1_value = dsp_wake1_s ? i_wb_value : i_dsp_src1_value;
        dsp_op_s.dst_rob    = i_dsp_dst_rob;
        dsp_op_s.imm        = i_dsp_imm;
        dsp_op_s.fid        = i_dsp_fid;
        dsp_op_s.bru_cmd    = i_dsp_bru_cmd;
        dsp_op_s.bagu_cmd   = i_dsp_bagu_cmd;
        dsp_op_s.bp_pattern = i_dsp_bp_pattern;
        dsp_op_s.bp_taken   = i_dsp_bp_taken;
        dsp_op_s.bp_hit     = i_dsp_bp_hit;
        dsp_op_s.bp_target  = i_dsp_bp_target;
    end

    // Tag match against the writeback bus and issue-candidate vector.
    always_comb begin
        wake0_s = '0;
        wake1_s = '0;
        cand_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake0_s[i] = i_wb_valid & valid_r[i] & ~src0_rdy_r[i] & (src0_rob_r[i] == i_wb_rob);
            wake1_s[i] = i_wb_valid & valid_r[i] & ~src1_rdy_r[i] & (src1_rob_r[i] == i_wb_rob);
            cand_s[i]  = valid_r[i] & src0_rdy_r[i] & src1_rdy_r[i];
        end
    end

    bru_issue_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .cand  (cand_s),
        .age   (age_r),
        .grant (grant_s),
        .any   (any_s)
    );

    assign iss_valid_s = any_s & ~i_flush & ~reset;
    assign iss_fire_s  = iss_valid_s & i_iss_ready;

    // Next valid bits, age matrix and occupancy; flush clears everything.
    always_comb begin
        valid_nxt_s = '0;
        age_nxt_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_nxt_s[i] = ~i_flush & ((valid_r[i] & ~(iss_fire_s & grant_s[i]))
                                         | (dsp_acc_s & alloc_s[i]));
            for (int j = 0; j < DEPTH; j++) begin
                age_nxt_s[i][j] = ~i_flush
                                & ~(iss_fire_s & (grant_s[i] | grant_s[j]))
                                & ((age_r[i][j] & ~(dsp_acc_s & alloc_s[i]))
                                   | (dsp_acc_s & alloc_s[j] & valid_r[i]));
            end
        end
        if (i_flush) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CNT_W'(dsp_acc_s) - CNT_W'(iss_fire_s);
        end
    end

    // Occupancy, valid bits and age matrix registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            age_r   <= '0;
            count_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            age_r   <= age_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Per-entry operand readiness, tags and payload capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src0_rdy_r <= '0;
            src1_rdy_r <= '0;
            src0_rob_r <= '0;
            src1_rob_r <= '0;
            op_r       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dsp_acc_s && alloc_s[i]) begin
                    src0_rdy_r[i] <= i_dsp_src0_rdy | dsp_wake0_s;
                    src1_rdy_r[i] <= i_dsp_src1_rdy | dsp_wake1_s;
                    src0_rob_r[i] <= i_dsp_src0_rob;
                    src1_rob_r[i] <= i_dsp_src1_rob;
                    op_r[i]       <= dsp_op_s;
                end else if (i_flush) begin
                    src0_rdy_r[i] <= 1'b0;
                    src1_rdy_r[i] <= 1'b0;
                end else begin
                    if (wake0_s[i]) begin
                        src0_rdy_r[i]         <= 1'b1;
                        op_r[i].src0_value    <= i_wb_value;
                    end
                    if (wake1_s[i]) begin
                        src1_rdy_r[i]         <= 1'b1;
                        op_r[i].src1_value    <= i_wb_value;
                    end
                end
            end
        end
    end

    // One-hot mux of the winning entry; payload forced to zero when not issuing.
    always_comb begin
        sel_op_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_op_s = bru_op_t'(sel_op_s | (op_r[i] & {BRU_OP_W{grant_s[i]}}));
        end
        if (iss_valid_s) begin
            iss_op_s = sel_op_s;
        end else begin
            iss_op_s = '0;
        end
    end

    assign o_dsp_ready      = dsp_ready_s;
    assign o_count          = count_r;
    assign o_iss_valid      = iss_valid_s;
    assign o_iss_pc         = iss_op_s.pc;
    assign o_iss_src0_value = iss_op_s.src0_value;
    assign o_iss_src1_value = iss_op_s.src1_value;
    assign o_iss_dst_rob    = iss_op_s.dst_rob;
    assign o_iss_imm        = iss_op_s.imm;
    assign o_iss_fid        = iss_op_s.fid;
    assign o_iss_bru_cmd    = iss_op_s.bru_cmd;
    assign o_iss_bagu_cmd   = iss_op_s.bagu_cmd;
    assign o_iss_bp_pattern = iss_op_s.bp_pattern;
    assign o_iss_bp_taken   = iss_op_s.bp_taken;
    assign o_iss_bp_hit     = iss_op_s.bp_hit;
    assign o_iss_bp_target  = iss_op_s.bp_target;

endmodule

// File: tb/tb_bru_issue_queue.sv
// Scoreboard bench for bru_issue_queue: every op that must issue is queued in
// expected order at dispatch; a negedge monitor pops and compares each issue.
module tb_bru_issue_queue;

    logic        clk;
    logic        reset;
    logic        i_dsp_valid;
    logic        o_dsp_ready;
    logic [31:0] i_dsp_pc;
    logic [3:0]  i_dsp_src0_rob;
    logic [3:0]  i_dsp_src1_rob;
    logic        i_dsp_src0_rdy;
    logic        i_dsp_src1_rdy;
    logic [31:0] i_dsp_src0_value;
    logic [31:0] i_dsp_src1_value;
    logic [3:0]  i_dsp_dst_rob;
    logic [25:0] i_dsp_imm;
    logic [7:0]  i_dsp_fid;
    logic [6:0]  i_dsp_bru_cmd;
    logic [1:0]  i_dsp_bagu_cmd;
    logic [1:0]  i_dsp_bp_pattern;
    logic        i_dsp_bp_taken;
    logic        i_dsp_bp_hit;
    logic [31:0] i_dsp_bp_target;
    logic        i_wb_valid;
    logic [3:0]  i_wb_rob;
    logic [31:0] i_wb_value;
    logic        i_flush;
    logic        i_iss_ready;
    logic        o_iss_valid;
    logic [31:0] o_iss_pc;
    logic [31:0] o_iss_src0_value;
    logic [31:0] o_iss_src1_value;
    logic [3:0]  o_iss_dst_rob;
    logic [25:0] o_iss_imm;
    logic [7:0]  o_iss_fid;
    logic [6:0]  o_iss_bru_cmd;
    logic [1:0]  o_iss_bagu_cmd;
    logic [1:0]  o_iss_bp_pattern;
    logic        o_iss_bp_taken;
    logic        o_iss_bp_hit;
    logic [31:0] o_iss_bp_target;
    logic [2:0]  o_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [3:0]  dst;
        logic [25:0] imm;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bru_issue_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_dsp_valid      (i_dsp_valid),
        .o_dsp_ready      (o_dsp_ready),
        .i_dsp_pc         (i_dsp_pc),
        .i_dsp_src0_rob   (i_dsp_src0_rob),
        .i_dsp_src1_rob   (i_dsp_src1_rob),
        .i_dsp_src0_rdy   (i_dsp_src0_rdy),
        .i_dsp_src1_rdy   (i_dsp_src1_rdy),
        .i_dsp_src0_value (i_dsp_src0_value),
        .i_dsp_src1_value (i_dsp_src1_value),
        .i_dsp_dst_rob    (i_dsp_dst_rob),
        .i_dsp_imm        (i_dsp_imm),
        .i_dsp_fid        (i_dsp_fid),
        .i_dsp_bru_cmd    (i_dsp_bru_cmd),
        .i_dsp_bagu_cmd   (i_dsp_bagu_cmd),
        .i_dsp_bp_pattern (i_dsp_bp_pattern),
        .i_dsp_bp_taken   (i_dsp_bp_taken),
        .i_dsp_bp_hit     (i_dsp_bp_hit),
        .i_dsp_bp_target  (i_dsp_bp_target),
        .i_wb_valid       (i_wb_valid),
        .i_wb_rob         (i_wb_rob),
        .i_wb_value       (i_wb_value),
        .i_flush          (i_flush),
        .i_iss_ready      (i_iss_ready),
        .o_iss_valid      (o_iss_valid),
        .o_iss_pc         (o_iss_pc),
        .o_iss_src0_value (o_iss_src0_value),
        .o_iss_src1_value (o_iss_src1_value),
        .o_iss_dst_rob    (o_iss_dst_rob),
        .o_iss_imm        (o_iss_imm),
        .o_iss_fid        (o_iss_fid),
        .o_iss_bru_cmd    (o_iss_bru_cmd),
        .o_iss_bagu_cmd   (o_iss_bagu_cmd),
        .o_iss_bp_pattern (o_iss_bp_pattern),
        .o_iss_bp_taken   (o_iss_bp_taken),
        .o_iss_bp_hit     (o_iss_bp_hit),
        .o_iss_bp_target  (o_iss_bp_target),
        .o_count          (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive a dispatch; side fields are derived from pc so the monitor can check them.
    task automatic set_dsp(input logic v, input logic [31:0] pc, input logic [3:0] r0,
                           input logic rdy0, input logic [31:0] v0, input logic [31:0] v1);
        i_dsp_valid      = v;
        i_dsp_pc         = pc;
        i_dsp_src0_rob   = r0;
        i_dsp_src0_rdy   = rdy0;
        i_dsp_src0_value = v0;
        i_dsp_src1_rob   = 4'hF;
        i_dsp_src1_rdy   = 1'b1;
        i_dsp_src1_value = v1;
        i_dsp_dst_rob    = pc[5:2];
        i_dsp_imm        = pc[27:2];
        i_dsp_fid        = pc[9:2];
        i_dsp_bru_cmd    = 7'h11;
        i_dsp_bagu_cmd   = 2'b01;
        i_dsp_bp_pattern = 2'b10;
        i_dsp_bp_taken   = 1'b1;
        i_dsp_bp_hit     = 1'b0;
        i_dsp_bp_target  = ~pc;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] s0, input logic [31:0] s1);
        exp_t e;
        e.pc  = pc;
        e.s0  = s0;
        e.s1  = s1;
        e.dst = pc[5:2];
        e.imm = pc[27:2];
        e.tgt = ~pc;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: each accepted issue must match the oldest expectation.
    always @(negedge clk) begin
        if (o_iss_valid === 1'b1 && i_iss_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected got pc=%h, required no issue", o_iss_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_iss_pc !== e.pc || o_iss_src0_value !== e.s0 || o_iss_src1_value !== e.s1 ||
                    o_iss_dst_rob !== e.dst || o_iss_imm !== e.imm || o_iss_bp_target !== e.tgt ||
                    o_iss_bru_cmd !== 7'h11 || o_iss_bagu_cmd !== 2'b01 || o_iss_bp_pattern !== 2'b10) begin
                    n_fail++;
                    $display("FAIL issue_payload got pc=%h s0=%h s1=%h dst=%h imm=%h, required pc=%h s0=%h s1=%h dst=%h imm=%h",
                             o_iss_pc, o_iss_src0_value, o_iss_src1_value, o_iss_dst_rob, o_iss_imm,
                             e.pc, e.s0, e.s1, e.dst, e.imm);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b0 || o_dsp_ready !== 1'b0 || o_count !== 3'd0 || o_iss_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state got valid=%b ready=%b count=%0d pc=%h, required 0 0 0 0",
                     o_iss_valid, o_dsp_ready, o_count, o_iss_pc);
        end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_dsp_ready !== 1'b1 || o_count !== 3'd0 || o_iss_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got ready=%b count=%0d valid=%b, required 1 0 0",
                     o_dsp_ready, o_count, o_iss_valid);
        end
        cyc();
    endtask

    task automatic test_single();
        i_iss_ready = 1'b1;
        set_dsp(1'b1, 32'h00400010, 4'h0, 1'b1, 32'h11, 32'h22);
        push_exp(32'h00400010, 32'h11, 32'h22);
        @(negedge clk);
        n_checks++;
        if (o_dsp_ready !== 1'b1 || o_iss_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_dispatch_cycle got ready=%b valid=%b, required 1 0", o_dsp_ready, o_iss_valid);
        end
        cyc();
        i_dsp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b1 || o_iss_pc !== 32'h00400010 || o_count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_issue got valid=%b pc=%h count=%0d, required 1 00400010 1",
                     o_iss_valid, o_iss_pc, o_count);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b0 || o_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drained got valid=%b count=%0d, required 0 0", o_iss_valid, o_count);
        end
        cyc();
    endtask

    task automatic test_wakeup();
        i_iss_ready = 1'b1;
        set_dsp(1'b1, 32'h00000100, 4'h3, 1'b0, 32'h00000BAD, 32'hA1);
        @(negedge clk);
        cyc();
        set_dsp(1'b1, 32'h00000200, 4'h0, 1'b1, 32'hB0, 32'hB1);
        push_exp(32'h00000200, 32'hB0, 32'hB1);
        push_exp(32'h00000100, 32'h55, 32'hA1);
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wakeup_a_waits got valid=%b pc=%h, required 0", o_iss_valid, o_iss_pc);
        end
        cyc();
        i_dsp_valid = 1'b0;
        i_wb_valid  = 1'b1;
        i_wb_rob    = 4'h3;
        i_wb_value  = 32'h55;
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b1 || o_iss_pc !== 32'h00000200) begin
            n_fail++;
            $display("FAIL wakeup_b_first got valid=%b pc=%h, required 1 00000200", o_iss_valid, o_iss_pc);
        end
        cyc();
        i_wb_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b1 || o_iss_pc !== 32'h00000100 || o_iss_src0_value !== 32'h55) begin
            n_fail++;
            $display("FAIL wakeup_a_issue got valid=%b pc=%h src0=%h, required 1 00000100 00000055",
                     o_iss_valid, o_iss_pc, o_iss_src0_value);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        i_iss_ready = 1'b0;
        set_dsp(1'b1, 32'h00000300, 4'h0, 1'b1, 32'hC0, 32'hC1);
        push_exp(32'h00000300, 32'hC0, 32'hC1);
        @(negedge clk);
        cyc();
        set_dsp(1'b1, 32'h00000304, 4'h0, 1'b1, 32'hD0, 32'hD1);
        push_exp(32'h00000304, 32'hD0, 32'hD1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_iss_valid !== 1'b1 || o_iss_pc !== 32'h00000300) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d got valid=%b pc=%h, required 1 00000300",
                         k, o_iss_valid, o_iss_pc);
            end
            cyc();
            i_dsp_valid = 1'b0;
        end
        i_iss_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_iss_pc !== 32'h00000300) begin
            n_fail++;
            $display("FAIL backpressure_first got pc=%h, required 00000300", o_iss_pc);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b1 || o_iss_pc !== 32'h00000304) begin
            n_fail++;
            $display("FAIL backpressure_second got valid=%b pc=%h, required 1 00000304", o_iss_valid, o_iss_pc);
        end
        cyc();
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b0 || o_count !== 3'd0) begin
            n_fail++;
            $display("FAIL backpressure_empty got valid=%b count=%0d, required 0 0", o_iss_valid, o_count);
        end
        cyc();
    endtask

    task automatic test_full();
        i_iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_dsp(1'b1, 32'h00001000 + 32'(k * 4), 4'h0, 1'b1, 32'(k), 32'(k + 16));
            push_exp(32'h00001000 + 32'(k * 4), 32'(k), 32'(k + 16));
            @(negedge clk);
            n_checks++;
            if (o_dsp_ready !== 1'b1 || o_count !== 3'(k)) begin
                n_fail++;
                $display("FAIL full_fill%0d got ready=%b count=%0d, required 1 %0d", k, o_dsp_ready, o_count, k);
            end
            cyc();
        end
        set_dsp(1'b1, 32'hDEAD0000, 4'h0, 1'b1, 32'hEE, 32'hEE);
        @(negedge clk);
        n_checks++;
        if (o_dsp_ready !== 1'b0 || o_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state got ready=%b count=%0d, required 0 4", o_dsp_ready, o_count);
        end
        cyc();
        i_dsp_valid = 1'b0;
        i_iss_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_count !== 3'd4 || o_iss_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_fifth_ignored got count=%0d valid=%b, required 4 1", o_count, o_iss_valid);
        end
        cyc();
        i_iss_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_dsp_ready !== 1'b1 || o_count !== 3'd3) begin
            n_fail++;
            $display("FAIL full_slot_freed got ready=%b count=%0d, required 1 3", o_dsp_ready, o_count);
        end
        cyc();
        i_iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if (o_count !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain got count=%0d pending=%0d, required 0 0", o_count, exp_q.size());
        end
        cyc();
    endtask

    task automatic test_flush();
        i_iss_ready = 1'b0;
        set_dsp(1'b1, 32'h00002000, 4'h0, 1'b1, 32'h1, 32'h2);
        @(negedge clk);
        cyc();
        set_dsp(1'b1, 32'h00002004, 4'h0, 1'b1, 32'h3, 32'h4);
        i_iss_ready = 1'b1;
        i_flush     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_iss_valid !== 1'b0 || o_iss_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL flush_blocks_issue got valid=%b pc=%h, required 0 0", o_iss_valid, o_iss_pc);
        end
        cyc();
        i_flush     = 1'b0;
        i_dsp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_count !== 3'd0 || o_iss_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cleared got count=%0d valid=%b, required 0 0", o_count, o_iss_valid);
        end
        cyc();
        @(negedge clk);
        cyc();
    endtask

    task automatic test_reset_mid();
        i_iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_dsp(1'b1, 32'h00003000 + 32'(k * 4), 4'h0, 1'b1, 32'h9, 32'h9);
            @(negedge clk);
            cyc();
        end
        i_dsp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_count !== 3'd3 || o_iss_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_held got count=%0d valid=%b, required 3 1", o_count, o_iss_valid);
        end
        cyc();
        reset = 1'b1;
        #1;
        n_checks++;
        if (o_iss_valid !== 1'b0 || o_dsp_ready !== 1'b0 || o_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async got valid=%b ready=%b count=%0d, required 0 0 0",
                     o_iss_valid, o_dsp_ready, o_count);
        end
        cyc();
        reset       = 1'b0;
        i_iss_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_count !== 3'd0 || o_dsp_ready !== 1'b1 || o_iss_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release got count=%0d ready=%b valid=%b, required 0 1 0",
                     o_count, o_dsp_ready, o_iss_valid);
        end
        cyc();
        @(negedge clk);
        cyc();
    endtask

    initial begin
        reset       = 1'b1;
        i_flush     = 1'b0;
        i_iss_ready = 1'b0;
        i_wb_valid  = 1'b0;
        i_wb_rob    = 4'h0;
        i_wb_value  = 32'h0;
        set_dsp(1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        test_reset();
        test_single();
        test_wakeup();
        test_backpressure();
        test_full();
        test_flush();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d pending issues, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bru_issue_queue.md
Name: bru_issue_queue

Overview:
- Out-of-order reservation station for the single branch unit (execute_bru).
- Holds up to DEPTH dispatched branch/jump ops and captures operands from the writeback bus by ROB tag.
- Each cycle, issues the oldest entry with both operands ready. Its issue port is wired 1:1 to the BRU input bundle.
- Whole-queue flush on branch-commit-override (mispredict).

Parameters:
- DEPTH, 4, number of entries (power of two, 2..8)
- CNT_W, 3, width of o_count, equal to log2(DEPTH)+1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_dsp_valid  in  1  dispatch request
- o_dsp_ready  out  1  queue can accept a dispatch this cycle
- i_dsp_pc  in  32  branch PC
- i_dsp_src0_rob / i_dsp_src1_rob  in  4  producer ROB tags
- i_dsp_src0_rdy / i_dsp_src1_rdy  in  1  operand already available
- i_dsp_src0_value / i_dsp_src1_value  in  32  operand value, valid when rdy=1
- i_dsp_dst_rob  in  4;  i_dsp_imm  in  26;  i_dsp_fid  in  8
- i_dsp_bru_cmd  in  7;  i_dsp_bagu_cmd  in  2
- i_dsp_bp_pattern  in  2;  i_dsp_bp_taken  in  1;  i_dsp_bp_hit  in  1;  i_dsp_bp_target  in  32
- i_wb_valid  in  1;  i_wb_rob  in  4;  i_wb_value  in  32  writeback wakeup bus
- i_flush  in  1  mispredict flush (driven from the BRU bco_valid)
- i_iss_ready  in  1  BRU can accept an op
- o_iss_valid  out  1;  o_iss_pc  out  32;  o_iss_src0_value / o_iss_src1_value  out  32
- o_iss_dst_rob  out  4;  o_iss_imm  out  26;  o_iss_fid  out  8;  o_iss_bru_cmd  out  7;  o_iss_bagu_cmd  out  2
- o_iss_bp_pattern  out  2;  o_iss_bp_taken  out  1;  o_iss_bp_hit  out  1;  o_iss_bp_target  out  32
- o_count  out  CNT_W  occupied entries

Behaviour:
- Reset (async, active-high):
  - all entry valid bits, ready bits and the age matrix clear.
  - o_count=0, o_iss_valid=0, all o_iss_* payload=0.
  - o_dsp_ready=0 while reset is high; o_dsp_ready=1 on the first cycle after release.
- Entry state: valid, src0/src1 ready+value, payload, and an age row (age[i][j]=1 means i is older than j).
- o_dsp_ready = (o_count != DEPTH). It is derived from registered state only; a same-cycle issue does not free a slot for a same-cycle dispatch.
- Dispatch (i_dsp_valid & o_dsp_ready & !i_flush):
  - writes the lowest-index free entry at the clock edge.
  - sets age[new][*]=0 and age[k][new]=1 for every currently valid k.
  - the entry becomes eligible to issue on the next cycle (minimum dispatch-to-issue latency 1).
- Dispatch-cycle wakeup: if i_wb_valid and i_wb_rob matches a dispatching src with rdy=0, that src is written ready with i_wb_value.
- Wakeup: each valid entry with srcN not ready and srcN_rob==i_wb_rob while i_wb_valid sets ready and captures the value at the edge. The entry is visible as ready next cycle; there is no same-cycle bypass into select.
- Select: candidates are valid entries with both srcs ready. The winner is the candidate with no older candidate. This is combinational from registered state.
- Issue:
  - o_iss_valid = any candidate & !i_flush & !reset.
  - the payload is the winner's fields; it is driven 0 when o_iss_valid=0.
  - on o_iss_valid & i_iss_ready, the winner's valid bit and age row/column clear at the edge.
  - with i_iss_ready=0, the output holds; the winner may change only if a new older candidate becomes ready.
- Flush: i_flush=1 clears every entry at the edge; o_count=0 next cycle.
  - flush wins over a simultaneous dispatch (op dropped) and a simultaneous issue (not issued, o_iss_valid=0).
- o_count: registered, next = count + dispatch_accepted − issue_fired (0 on flush). Simultaneous dispatch+issue leaves it unchanged.
- No ordering between wakeup tags and dispatch tags is checked. Duplicate producer tags in flight are illegal upstream.

Decomposition:
- Shared package holds:
  - widths PC_W=32, ROB_W=4, FID_W=8, IMM_W=26, BRU_CMD_W=7, BAGU_CMD_W=2, BP_PAT_W=2.
  - a packed BRU op payload typedef reused by execute_bru and this block.
- One sub-module, bru_issue_age_select: it takes the DEPTH-bit candidate vector and the age matrix, and returns a one-hot oldest-grant plus an any-flag.

Test Plan:
- Dispatch 1 op, both rdy=1, pc=0x00400010, i_iss_ready=1 -> o_iss_valid=1 on the next cycle with o_iss_pc=0x00400010, and o_count goes 1 -> 0.
- Dispatch A (src0_rob=3, rdy=0), then B (ready); pulse wb rob=3, value=0x55 -> B issues first; A issues 1 cycle after the wakeup with o_iss_src0_value=0x55.
- Dispatch A then B, both ready, i_iss_ready=0 for 3 cycles -> o_iss_pc holds A's pc; after release, A then B issue in consecutive cycles.
- Fill 4 entries with i_iss_ready=0 -> o_dsp_ready=0 and o_count=4; a 5th dispatch is ignored; one issue brings o_dsp_ready back to 1 next cycle.
- Flush in the same cycle as a dispatch and a pending issue -> o_iss_valid=0 that cycle; o_count=0 next cycle; the dropped op never appears.
- Assert reset mid-operation with 3 entries held -> o_iss_valid=0 and o_dsp_ready=0 immediately; after release o_count=0 and o_dsp_ready=1.
